// File: rtl/serdes_link_pkg.sv
// Shared types and constants for the LVDS link trainer.
// Holds the trainer state encoding, the default training word and the
// serd_cmd tristate encodings used by serdes_link_trainer and serdes_lane_align.
package serdes_link_pkg;

    // Trainer sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        ENABLE,
        CHECK,
        SLIP,
        WAIT,
        LOCKED,
        ERROR
    } trainer_state_t;

    // 8'h1E has eight distinct rotations, so each bitslip position is unambiguous.
    localparam logic [7:0] TRAIN_PATTERN_DEFAULT = 8'h1E;

    // serd_cmd encodings, one bit per tx port; 1 = tristated.
    localparam logic [1:0] SERD_TRISTATE = 2'b11;
    localparam logic [1:0] SERD_DRIVE    = 2'b00;

endpackage

// File: rtl/serdes_lane_align.sv
// Per-lane alignment tracker for the LVDS link trainer.
// Counts consecutive training-word matches while the trainer is checking,
// flags the lane for a bitslip on a mismatch and counts the slips issued.
// Once a lane has LOCK_COUNT consecutive matches it is aligned and frozen.
module serdes_lane_align
    import serdes_link_pkg::*;
#(
    parameter int                LANE_W        = 8,
    parameter logic [LANE_W-1:0] TRAIN_PATTERN = LANE_W'(TRAIN_PATTERN_DEFAULT),
    parameter int                LOCK_COUNT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              check_en,
    input  logic              slip_en,
    input  logic [LANE_W-1:0] rx_word,
    output logic              bitslip,
    output logic              pending,
    output logic              aligned,
    output logic              slip_exhaust
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int SLIP_W  = $clog2(LANE_W + 1);

    logic [MATCH_W-1:0] match_cnt;
    logic [SLIP_W-1:0]  slip_cnt;
    logic               word_ok;

    assign word_ok = (rx_word == TRAIN_PATTERN);

    // Slip pulse only for a lane that is waiting for one, and only in SLIP.
    assign bitslip = slip_en && pending;

    // This slip will be the LANE_W-th: every rotation has been tried.
    assign slip_exhaust = pending && (slip_cnt == SLIP_W'(LANE_W - 1));

    // Match/slip bookkeeping for one lane.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
            slip_cnt  <= '0;
            pending   <= 1'b0;
            aligned   <= 1'b0;
        end else if (clear) begin
            match_cnt <= '0;
            slip_cnt  <= '0;
            pending   <= 1'b0;
            aligned   <= 1'b0;
        end else if (check_en && !aligned && !pending) begin
            // Aligned lanes stop evaluating, so match_cnt saturates at LOCK_COUNT.
            if (word_ok) begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                    aligned <= 1'b1;
                end
            end else begin
                match_cnt <= '0;
                pending   <= 1'b1;
            end
        end else if (slip_en && pending) begin
            slip_cnt <= slip_cnt + 1'b1;
            pending  <= 1'b0;
        end
    end

endmodule

// File: rtl/serdes_link_trainer.sv
// LVDS link bring-up sequencer for the 5-lane serdes pair.
// Enables the tx drivers with the training pattern, waits for the link to
// settle, then bit-slips each rx lane until all lanes see the training word
// for LOCK_COUNT consecutive cycles, and finally reports link_up.
// Optional feature: define SERDES_AUTO_RETRAIN_EN to retry training
// automatically (up to MAX_RETRIES times, RETRY_DELAY cycles apart) after
// ERROR; without it ERROR is terminal until start or reset.
module serdes_link_trainer
    import serdes_link_pkg::*;
#(
    parameter int                NUM_LANES     = 5,
    parameter int                LANE_W        = 8,
    parameter logic [LANE_W-1:0] TRAIN_PATTERN = LANE_W'(TRAIN_PATTERN_DEFAULT),
    parameter int                SETTLE_CYCLES = 64,
    parameter int                SLIP_WAIT     = 4,
    parameter int                LOCK_COUNT    = 16,
    parameter int                RETRY_DELAY   = 256,
    parameter int                MAX_RETRIES   = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_LANES*LANE_W-1:0] rx_lane_data,
    output logic [1:0]                  serd_cmd,
    output logic                        tx_train_en,
    output logic [NUM_LANES-1:0]        bitslip,
    output logic [NUM_LANES-1:0]        lane_aligned,
    output logic                        link_up,
    output logic                        train_err,
    output logic                        busy
);

    // Wide enough for the longest wait (settle, slip or retry delay).
    localparam int TIMER_W = 16;

    trainer_state_t state, state_next;

    logic [TIMER_W-1:0]   timer;
    logic                 timer_clr;
    logic                 check_en;
    logic                 slip_en;
    logic                 retry_go;
    logic                 lane_clear;
    logic [NUM_LANES-1:0] lane_pending;
    logic [NUM_LANES-1:0] lane_exhaust;

    // Entering ENABLE, by start or by an automatic retry, wipes lane history.
    assign lane_clear = start || retry_go;

    // Every state change restarts the shared timer; start restarts ENABLE too.
    assign timer_clr = start || (state_next != state);

    // Per-lane trackers.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        serdes_lane_align #(
            .LANE_W        (LANE_W),
            .TRAIN_PATTERN (TRAIN_PATTERN),
            .LOCK_COUNT    (LOCK_COUNT)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .clear        (lane_clear),
            .check_en     (check_en),
            .slip_en      (slip_en),
            .rx_word      (rx_lane_data[i*LANE_W +: LANE_W]),
            .bitslip      (bitslip[i]),
            .pending      (lane_pending[i]),
            .aligned      (lane_aligned[i]),
            .slip_exhaust (lane_exhaust[i])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shared settle/slip-wait/retry timer; saturates rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + 1'b1;
        end
    end

`ifdef SERDES_AUTO_RETRAIN_EN
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_due;

    assign retry_due = (retry_cnt < RETRY_W'(MAX_RETRIES)) &&
                       (timer == TIMER_W'(RETRY_DELAY - 1));

    // Counts automatic retries since the last start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if (start) begin
            retry_cnt <= '0;
        end else if (retry_go) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    logic        retry_due;
    logic [31:0] unused_retry_cfg;

    assign retry_due        = 1'b0;
    assign unused_retry_cfg = 32'(RETRY_DELAY) ^ 32'(MAX_RETRIES);
`endif

    // Next-state and output decode.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        serd_cmd    = SERD_DRIVE;
        tx_train_en = 1'b0;
        busy        = 1'b0;
        link_up     = 1'b0;
        train_err   = 1'b0;
        check_en    = 1'b0;
        slip_en     = 1'b0;
        retry_go    = 1'b0;

        case (state)
            IDLE: begin
                serd_cmd = SERD_TRISTATE;
            end
            ENABLE: begin
                tx_train_en = 1'b1;
                busy        = 1'b1;
                if (timer == TIMER_W'(SETTLE_CYCLES - 1)) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                tx_train_en = 1'b1;
                busy        = 1'b1;
                check_en    = 1'b1;
                if (|lane_pending) begin
                    state_next = SLIP;
                end else if (&lane_aligned) begin
                    state_next = LOCKED;
                end
            end
            SLIP: begin
                tx_train_en = 1'b1;
                busy        = 1'b1;
                slip_en     = 1'b1;
                state_next  = (|lane_exhaust) ? ERROR : WAIT;
            end
            WAIT: begin
                tx_train_en = 1'b1;
                busy        = 1'b1;
                if (timer == TIMER_W'(SLIP_WAIT - 1)) begin
                    state_next = CHECK;
                end
            end
            LOCKED: begin
                // Payload is flowing now, so rx mismatches are deliberately ignored.
                link_up = 1'b1;
            end
            ERROR: begin
                serd_cmd  = SERD_TRISTATE;
                train_err = 1'b1;
                if (retry_due) begin
                    retry_go   = 1'b1;
                    state_next = ENABLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // start overrides everything: restart training from the top.
        if (start) begin
            state_next = ENABLE;
            retry_go   = 1'b0;
        end
    end

endmodule

// File: tb/tb_serdes_link_trainer.sv
// Self-checking bench for serdes_link_trainer.
// A small serdes model rotates a lane's rx word right by one bit per bitslip
// pulse. Each training run pushes its expected outcome onto a scoreboard,
// which is drained once link_up or train_err appears.
module tb_serdes_link_trainer;

    localparam int         NL  = 5;
    localparam int         LW  = 8;
    localparam logic [7:0] PAT = 8'h1E;

    typedef enum int {OBS_LAT, OBS_SLIPS, OBS_ALIGNED, OBS_LINK, OBS_ERR,
                      OBS_CMD, OBS_BUSY, OBS_TRAIN} obs_t;

    typedef struct {
        obs_t        kind;
        int          lane;
        logic [31:0] exp;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [NL*LW-1:0] rx_lane_data;
    logic [1:0]       serd_cmd;
    logic             tx_train_en;
    logic [NL-1:0]    bitslip;
    logic [NL-1:0]    lane_aligned;
    logic             link_up;
    logic             train_err;
    logic             busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         lat_obs = 0;
    int         last_slip_cyc = -1;
    bit         rot_en = 1'b0;
    logic [7:0] base [NL];
    int         rot [NL];
    int         slip_seen [NL];
    exp_t       sb [$];

    serdes_link_trainer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_lane_data (rx_lane_data),
        .serd_cmd     (serd_cmd),
        .tx_train_en  (tx_train_en),
        .bitslip      (bitslip),
        .lane_aligned (lane_aligned),
        .link_up      (link_up),
        .train_err    (train_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] w, input int n);
        logic [7:0] r = w;
        for (int k = 0; k < n % LW; k++) r = {r[0], r[7:1]};
        return r;
    endfunction

    task automatic drive_rx();
        for (int i = 0; i < NL; i++) rx_lane_data[i*LW +: LW] = rotr(base[i], rot[i]);
    endtask

    // Serdes model and bitslip protocol monitor.
    always @(negedge clk) begin
        if (!reset && |bitslip) begin
            check("slip_busy", 32'(busy), 32'd1);
            if (last_slip_cyc >= 0) check("slip_gap", 32'(cyc - last_slip_cyc >= 5), 32'd1);
            last_slip_cyc = cyc;
            for (int i = 0; i < NL; i++) begin
                if (bitslip[i]) begin
                    slip_seen[i]++;
                    if (rot_en) rot[i]++;
                end
            end
            drive_rx();
        end
    end

    function automatic logic [31:0] observe(input exp_t e);
        case (e.kind)
            OBS_LAT:     return 32'(lat_obs);
            OBS_SLIPS:   return 32'(slip_seen[e.lane]);
            OBS_ALIGNED: return 32'(lane_aligned);
            OBS_LINK:    return 32'(link_up);
            OBS_ERR:     return 32'(train_err);
            OBS_CMD:     return 32'(serd_cmd);
            OBS_BUSY:    return 32'(busy);
            default:     return 32'(tx_train_en);
        endcase
    endfunction

    task automatic push(input obs_t kind, input int lane, input logic [31:0] exp);
        exp_t e;
        e.kind = kind;
        e.lane = lane;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Expected outcome of one training run; at most one lane needs slips.
    task automatic expect_result(input int lat, input int slip_lane, input int slip_num,
                                 input logic [4:0] aligned, input bit locked);
        push(OBS_LAT, 0, 32'(lat));
        for (int i = 0; i < NL; i++) push(OBS_SLIPS, i, 32'((i == slip_lane) ? slip_num : 0));
        push(OBS_ALIGNED, 0, 32'(aligned));
        push(OBS_LINK, 0, 32'(locked));
        push(OBS_ERR, 0, 32'(!locked));
        push(OBS_CMD, 0, locked ? 32'd0 : 32'd3);
        push(OBS_BUSY, 0, 32'd0);
        push(OBS_TRAIN, 0, 32'd0);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s%0d", e.kind.name(), e.lane), observe(e), e.exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) begin
            rot[i]       = 0;
            slip_seen[i] = 0;
        end
        last_slip_cyc = -1;
        drive_rx();
    endtask

    // Pulse start and verify the restart is visible one cycle later.
    task automatic pulse_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_link", 32'(link_up), 32'd0);
        check("start_err", 32'(train_err), 32'd0);
        check("start_aligned", 32'(lane_aligned), 32'd0);
        check("start_cmd", 32'(serd_cmd), 32'd0);
        check("start_train", 32'(tx_train_en), 32'd1);
    endtask

    // One training run; glitch_at >= 0 corrupts lane 1 for that one cycle.
    task automatic run_training(input int glitch_at);
        int t0;
        bit done = 1'b0;
        clear_model();
        pulse_start(t0);
        for (int k = 0; k < 2000; k++) begin
            if (cyc - t0 == glitch_at) begin
                base[1] = 8'h5A;
                drive_rx();
            end else if (cyc - t0 == glitch_at + 1) begin
                base[1] = PAT;
                drive_rx();
            end
            if (link_up || train_err) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        lat_obs = cyc - t0;
        drain();
    endtask

    initial begin
        int  t0;
        bit  seen;

        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NL; i++) base[i] = PAT;
        clear_model();
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_cmd", 32'(serd_cmd), 32'd3);
        check("rst_train", 32'(tx_train_en), 32'd0);
        check("rst_slip", 32'(bitslip), 32'd0);
        check("rst_aligned", 32'(lane_aligned), 32'd0);
        check("rst_link", 32'(link_up), 32'd0);
        check("rst_err", 32'(train_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_cmd", 32'(serd_cmd), 32'd3);

        // Ideal loopback: 1 + 64 + 16 + 1.
        rot_en = 1'b0;
        expect_result(82, -1, 0, 5'h1F, 1'b1);
        run_training(-1);

        // Lane 3 rotated by two bit positions.
        base[3] = 8'h78;
        rot_en  = 1'b1;
        expect_result(96, 3, 2, 5'h1F, 1'b1);
        run_training(-1);

        // Stuck lane 0: all eight rotations fail.
        base[0] = 8'h00;
        base[3] = PAT;
        rot_en  = 1'b0;
        expect_result(117, 0, 8, 5'h1E, 1'b0);
        run_training(-1);
        repeat (300) @(negedge clk);
`ifdef SERDES_AUTO_RETRAIN_EN
        check("retry_busy", 32'(busy), 32'd1);
        check("retry_err", 32'(train_err), 32'd0);
`else
        check("noretry_err", 32'(train_err), 32'd1);
        check("noretry_busy", 32'(busy), 32'd0);
`endif

        // Intermittent mismatch on lane 1 after 10 good CHECK cycles.
        base[0] = PAT;
        expect_result(99, 1, 1, 5'h1F, 1'b1);
        run_training(75);

        // Restart mid-training, then async reset during WAIT.
        base[0] = 8'h00;
        clear_model();
        pulse_start(t0);
        repeat (93) @(negedge clk);
        check("pre_restart_busy", 32'(busy), 32'd1);
        base[0] = PAT;
        base[3] = 8'h78;
        rot_en  = 1'b1;
        clear_model();
        pulse_start(t0);
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bitslip[3]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("restart_slip_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_cmd", 32'(serd_cmd), 32'd3);
        check("arst_train", 32'(tx_train_en), 32'd0);
        check("arst_slip", 32'(bitslip), 32'd0);
        check("arst_aligned", 32'(lane_aligned), 32'd0);
        check("arst_link", 32'(link_up), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(train_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd", 32'(serd_cmd), 32'd3);
        expect_result(96, 3, 2, 5'h1F, 1'b1);
        run_training(-1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_link_trainer.md
Name: serdes_link_trainer

Overview:
- Sequences LVDS link bring-up for the 5-lane serializer/deserializer pair (3 lanes on port 1, 2 lanes on port 2).
- Drives tx tristate/command bits and the training-pattern transmit enable.
- Watches received lane bytes and issues per-lane bitslip pulses until every lane shows the training pattern for LOCK_COUNT consecutive cycles, then asserts link_up.
- Sits between system control and the serdes wrapper; sole owner of serd_cmd and bitslip.

Parameters:
- NUM_LANES, 5, number of deserializer lanes.
- LANE_W, 8, bits per lane word.
- TRAIN_PATTERN, 8'h1E, training word; all LANE_W rotations are distinct.
- SETTLE_CYCLES, 64, wait after output enable before the first sample.
- SLIP_WAIT, 4, cycles after a bitslip pulse before resampling.
- LOCK_COUNT, 16, consecutive matches needed per lane.
- RETRY_DELAY, 256, idle cycles before auto-retry (optional feature only).
- MAX_RETRIES, 3, auto-retry limit (optional feature only).

Ports:
- clk  in  1  single clock, the serdes parallel clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins or restarts training.
- rx_lane_data  in  NUM_LANES*LANE_W  parallel rx words; lane i is bits [i*LANE_W +: LANE_W].
- serd_cmd  out  2  tristate controls for tx ports 1 and 2; 1 = tristated.
- tx_train_en  out  1  selects TRAIN_PATTERN on all tx lanes.
- bitslip  out  NUM_LANES  one-cycle slip pulses, one bit per lane.
- lane_aligned  out  NUM_LANES  per-lane lock status.
- link_up  out  1  all lanes locked.
- train_err  out  1  some lane exhausted LANE_W slips without locking.
- busy  out  1  training in progress.

Behaviour:
- Reset values: state IDLE; serd_cmd=2'b11; tx_train_en=0; bitslip=0; lane_aligned=0; link_up=0; train_err=0; busy=0; all counters 0.
- IDLE:
  - start -> ENABLE; all per-lane counters cleared.
  - serd_cmd stays 2'b11.
- ENABLE:
  - serd_cmd=2'b00, tx_train_en=1, busy=1.
  - Counts SETTLE_CYCLES, then -> CHECK.
- CHECK, evaluated each cycle, per lane in parallel:
  - Word matches TRAIN_PATTERN: match_cnt++ (saturates at LOCK_COUNT). lane_aligned[i]=1 once match_cnt==LOCK_COUNT.
  - Word mismatches before lock: match_cnt clears and the lane is marked slip-pending.
  - Any lane slip-pending -> SLIP.
  - All lanes locked -> LOCKED.
- SLIP:
  - One cycle. bitslip[i]=1 for each slip-pending lane only; slip_cnt[i]++.
  - Any slip_cnt reaches LANE_W -> ERROR; otherwise -> WAIT.
- WAIT:
  - bitslip=0 for SLIP_WAIT cycles, then -> CHECK.
  - Pending flags clear. Locked lanes stay locked and are never slipped again.
- LOCKED:
  - link_up=1, tx_train_en=0, busy=0, serd_cmd=2'b00.
  - Sticky until start or reset. Mismatches are ignored because payload flows.
- ERROR:
  - train_err=1, serd_cmd=2'b11, tx_train_en=0, busy=0.
  - lane_aligned holds the last value for debug.
- start in any non-IDLE state: immediate restart into ENABLE. Clears link_up, train_err, lane_aligned and all counters the next cycle.
- bitslip is never asserted on two consecutive cycles and never outside SLIP.
- Latency, best case (all lanes already aligned): start to link_up = 1 + SETTLE_CYCLES + LOCK_COUNT + 1 cycles.
- reset asserted mid-operation: all outputs return to reset values asynchronously.

Optional Feature:
- Macro: SERDES_AUTO_RETRAIN_EN.
- Defined:
  - ERROR waits RETRY_DELAY cycles with train_err=1, then re-enters ENABLE automatically.
  - retry_cnt increments on each retry.
  - After MAX_RETRIES failed retries, ERROR is terminal until start.
  - start clears retry_cnt.
- Undefined: ERROR is terminal until start or reset; no retry logic is synthesized.

Decomposition:
- Package serdes_link_pkg:
  - trainer state enum: IDLE, ENABLE, CHECK, SLIP, WAIT, LOCKED, ERROR.
  - TRAIN_PATTERN default.
  - SERD_TRISTATE=2'b11 and SERD_DRIVE=2'b00 constants.
- Sub-module serdes_lane_align, instantiated NUM_LANES times:
  - Holds match_cnt, slip_cnt, pending and aligned for one lane.
  - Top level holds the FSM and timers only.

Test Plan:
- Ideal loopback: rx = TRAIN_PATTERN on all lanes from the start; pulse start -> link_up at cycle 82 (1+64+16+1), bitslip never asserted, lane_aligned=5'h1F.
- Lane 3 rotated by 2: rx lane 3 = 8'h78, rotating one bit per bitslip pulse -> exactly 2 bitslip[3] pulses spaced ≥5 cycles; other lanes get 0 pulses; link_up follows.
- Stuck lane: rx lane 0 = 8'h00 permanently -> 8 pulses on bitslip[0], then train_err=1, serd_cmd=2'b11, lane_aligned=5'h1E.
- Intermittent mismatch: lane 1 matches for 10 cycles, one bad word, then matches -> match_cnt restarts, one slip issued, lock still achieved.
- start at cycle 30 of CHECK, then async reset mid-WAIT -> start restarts cleanly at ENABLE; reset forces serd_cmd=2'b11 and all other outputs 0 within the same cycle.
- With SERDES_AUTO_RETRAIN_EN, stuck lane -> 3 automatic retries each 256 cycles after ERROR entry, then terminal ERROR; without the macro, a single ERROR with no retry.
